// File: rtl/fft_output_reader_if.sv
// fft_output_reader_if: result-write and natural-order read channels.
// master is the reader's view, slave is the core/consumer view.
`timescale 1ns/1ps
interface fft_output_reader_if #(
    parameter int DW = 16
);
    logic          i_wr_valid;
    logic [DW-1:0] i_wr_re;
    logic [DW-1:0] i_wr_im;
    logic          o_wr_ready;
    logic          o_rd_valid;
    logic [DW-1:0] o_rd_re;
    logic [DW-1:0] o_rd_im;
    logic          o_rd_last;
    logic          i_rd_ready;

    modport master (
        input  i_wr_valid, i_wr_re, i_wr_im, i_rd_ready,
        output o_wr_ready, o_rd_valid, o_rd_re, o_rd_im, o_rd_last
    );

    modport slave (
        output i_wr_valid, i_wr_re, i_wr_im, i_rd_ready,
        input  o_wr_ready, o_rd_valid, o_rd_re, o_rd_im, o_rd_last
    );
endinterface

// File: rtl/fft_output_reader.sv
// fft_output_reader: captures 16 FFT results, streams them in bin order.
// Define FFT_READER_BITREV_EN for cores that emit bit-reversed results.
`timescale 1ns/1ps
module fft_output_reader #(
    parameter int DW = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_cycle_done,
    fft_output_reader_if.master  io_bus,
    output logic                 o_busy,
    output logic                 o_overflow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_DRAIN
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_done_q;
    logic [3:0]      r_wr_cnt;
    logic [3:0]      r_rd_ptr;
    logic            r_overflow;
    logic [2*DW-1:0] r_mem [16];

    logic            w_arm;
    logic            w_wr_fire;
    logic            w_rd_fire;
    logic            w_wr_last;
    logic [3:0]      w_wr_addr;
    logic [2*DW-1:0] w_rd_word;

    assign w_arm     = i_cycle_done & ~r_done_q;
    assign w_wr_fire = (r_state == S_FILL) & io_bus.i_wr_valid;
    assign w_rd_fire = (r_state == S_DRAIN) & io_bus.i_rd_ready;
    assign w_wr_last = w_wr_fire & (r_wr_cnt == 4'd15);

`ifdef FFT_READER_BITREV_EN
    assign w_wr_addr = {r_wr_cnt[0], r_wr_cnt[1], r_wr_cnt[2], r_wr_cnt[3]};
`else
    assign w_wr_addr = r_wr_cnt;
`endif

    assign w_rd_word  = r_mem[r_rd_ptr];
    assign o_overflow = r_overflow;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state: arm starts a frame, 16th write drains, 16th read idles
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_arm) w_next = S_FILL;
            S_FILL:  if (w_wr_last) w_next = S_DRAIN;
            S_DRAIN: if (w_rd_fire && r_rd_ptr == 4'd15) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state only
    always_comb begin
        io_bus.o_wr_ready = 1'b0;
        io_bus.o_rd_valid = 1'b0;
        io_bus.o_rd_last  = 1'b0;
        o_busy            = 1'b0;
        unique case (r_state)
            S_FILL: begin
                io_bus.o_wr_ready = 1'b1;
                o_busy            = 1'b1;
            end
            S_DRAIN: begin
                io_bus.o_rd_valid = 1'b1;
                io_bus.o_rd_last  = (r_rd_ptr == 4'd15);
                o_busy            = 1'b1;
            end
            default: begin
                o_busy = 1'b0;
            end
        endcase
    end

    // Read data is the addressed slot; only meaningful while valid
    always_comb begin
        io_bus.o_rd_re = w_rd_word[DW-1:0];
        io_bus.o_rd_im = w_rd_word[2*DW-1:DW];
    end

    // Counters, edge detector and sticky overflow
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_done_q   <= 1'b0;
            r_wr_cnt   <= 4'd0;
            r_rd_ptr   <= 4'd0;
            r_overflow <= 1'b0;
        end else begin
            r_done_q <= i_cycle_done;
            if (w_arm && r_state != S_IDLE) r_overflow <= 1'b1;
            if (w_arm && r_state == S_IDLE) r_wr_cnt <= 4'd0;
            else if (w_wr_fire)             r_wr_cnt <= r_wr_cnt + 4'd1;
            if (w_wr_last)                  r_rd_ptr <= 4'd0;
            else if (w_rd_fire)             r_rd_ptr <= r_rd_ptr + 4'd1;
        end
    end

    // Sample array; not reset, contents are dead until a full fill
    always_ff @(posedge i_clk) begin
        if (w_wr_fire) r_mem[w_wr_addr] <= {io_bus.i_wr_im, io_bus.i_wr_re};
    end

endmodule
